// File: rtl/bubble_page_fifo_tx.sv
// Page-dump receiver: captures bit-serial page writes into a ping-pong buffer and
// streams a framed page byte by byte to an FT232 in async 245 FIFO mode.
module bubble_page_fifo_tx #(
    parameter int          BOOT_BYTES = 128,
    parameter int          USER_BYTES = 64,
    parameter int          WR_PULSE   = 4,
    parameter logic [7:0]  HDR_BOOT   = 8'hB0,
    parameter logic [7:0]  HDR_USER   = 8'hC0
) (
    input  logic        MCLK,
    input  logic        nRST,
    input  logic        nEN,
    input  logic        nFIFOBUFWRCLKEN,
    input  logic [12:0] FIFOBUFWRADDR,
    input  logic        FIFOBUFWRDATA,
    input  logic        nFIFOSENDBOOT,
    input  logic        nFIFOSENDUSER,
    input  logic [11:0] FIFORELPAGE,
    output logic [7:0]  FT_DOUT,
    output logic        FT_DOE,
    input  logic        nFT_TXE,
    output logic        FT_WR,
    output logic        BUSY,
    output logic        nOVERRUN,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_WAIT   = 3'd2,
        S_STROBE = 3'd3,
        S_HOLD   = 3'd4
    } state_t;

    state_t      state;
    logic        fill_bank;
    logic        send_bank;
    logic [7:0]  mem [0:2047];
    logic [7:0]  rd_data;
    logic [10:0] byte_idx;
    logic [9:0]  data_addr;
    logic        fetch_ph;
    logic [11:0] page_q;
    logic        boot_q;
    logic [15:0] wr_cnt;
    logic        send_boot_q;
    logic        send_user_q;
    logic        boot_fall;
    logic        user_fall;
    logic [10:0] last_idx;

    // Frame byte index 0..2 is the header; data bytes start at index 3.
    assign data_addr = byte_idx[9:0] - 10'd3;
    assign boot_fall = send_boot_q & ~nFIFOSENDBOOT;
    assign user_fall = send_user_q & ~nFIFOSENDUSER;
    assign last_idx  = boot_q ? 11'(BOOT_BYTES + 2) : 11'(USER_BYTES + 2);
    assign state_dbg = state;

    always_ff @(posedge MCLK) begin
        if (nRST && !nEN && !nFIFOBUFWRCLKEN)
            mem[{fill_bank, FIFOBUFWRADDR[12:3]}][FIFOBUFWRADDR[2:0]] <= FIFOBUFWRDATA;
        rd_data <= mem[{send_bank, data_addr}];
    end

    // FT handshake: a byte is offered on FT_DOUT with FT_DOE=1; it is committed only
    // once nFT_TXE=0 is seen in WAIT, by a WR_PULSE-cycle FT_WR strobe with data held
    // one cycle either side.
    always_ff @(posedge MCLK) begin
        if (!nRST || nEN) begin
            state       <= S_IDLE;
            FT_DOUT     <= 8'h00;
            FT_DOE      <= 1'b0;
            FT_WR       <= 1'b0;
            BUSY        <= 1'b0;
            send_boot_q <= 1'b1;
            send_user_q <= 1'b1;
            byte_idx    <= 11'd0;
            fetch_ph    <= 1'b0;
            wr_cnt      <= 16'd0;
            if (!nRST) begin
                nOVERRUN  <= 1'b1;
                fill_bank <= 1'b0;
                send_bank <= 1'b0;
                page_q    <= 12'h000;
                boot_q    <= 1'b0;
            end
        end else begin
            send_boot_q <= nFIFOSENDBOOT;
            send_user_q <= nFIFOSENDUSER;
            if (state != S_IDLE && (boot_fall || user_fall))
                nOVERRUN <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    byte_idx <= 11'd0;
                    fetch_ph <= 1'b0;
                    if (boot_fall || user_fall) begin
                        page_q    <= FIFORELPAGE;
                        boot_q    <= boot_fall;
                        send_bank <= fill_bank;
                        fill_bank <= ~fill_bank;
                        BUSY      <= 1'b1;
                        state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    // First phase lets the registered RAM read settle.
                    if (!fetch_ph) begin
                        fetch_ph <= 1'b1;
                    end else begin
                        fetch_ph <= 1'b0;
                        FT_DOE   <= 1'b1;
                        case (byte_idx)
                            11'd0:   FT_DOUT <= boot_q ? HDR_BOOT : HDR_USER;
                            11'd1:   FT_DOUT <= {4'h0, page_q[11:8]};
                            11'd2:   FT_DOUT <= page_q[7:0];
                            default: FT_DOUT <= rd_data;
                        endcase
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (!nFT_TXE) begin
                        FT_WR  <= 1'b1;
                        wr_cnt <= 16'd0;
                        state  <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (wr_cnt == 16'(WR_PULSE - 1)) begin
                        FT_WR <= 1'b0;
                        state <= S_HOLD;
                    end else begin
                        wr_cnt <= wr_cnt + 16'd1;
                    end
                end
                S_HOLD: begin
                    if (byte_idx == last_idx) begin
                        FT_DOE <= 1'b0;
                        BUSY   <= 1'b0;
                        state  <= S_IDLE;
                    end else begin
                        byte_idx <= byte_idx + 11'd1;
                        state    <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
